// File: rtl/matvec_pkg.sv
// Shared types, default geometry and the rescale/saturate helper for the
// streaming matrix-vector engine.
package matvec_pkg;

    localparam int DEF_N  = 64;
    localparam int DEF_M  = 64;
    localparam int DEF_DW = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    // Arithmetic shift then clamp to the signed dw-bit range; caller keeps the low dw bits.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] acc,
        input int                 shift,
        input int                 dw
    );
        logic signed [63:0] shifted;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        shifted = acc >>> shift;
        hi      = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (dw - 1));
        if (shifted > hi) begin
            res = hi;
        end else if (shifted < lo) begin
            res = lo;
        end else begin
            res = shifted;
        end
        return res;
    endfunction

endpackage

// File: rtl/matvec_row_mac.sv
// One output row: its M weights, the signed accumulator and the saturated
// result derived from it.
module matvec_row_mac
    import matvec_pkg::*;
#(
    parameter int M     = DEF_M,
    parameter int DW    = DEF_DW,
    parameter int SHIFT = 0,
    parameter int ACC_W = 2 * DW + $clog2(M),
    parameter int IW    = (M > 1) ? $clog2(M) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [IW-1:0]        col,
    input  logic signed [DW-1:0] wdata,
    input  logic                 mac_en,
    input  logic [IW-1:0]        idx,
    input  logic signed [DW-1:0] din,
    input  logic                 clr,
    output logic [DW-1:0]        result
);

    logic signed [DW-1:0]    w_mem_r [M];
    logic signed [ACC_W-1:0] acc_r;
    logic signed [DW-1:0]    w_sel_s;
    logic signed [2*DW-1:0]  prod_s;

    // The MAC reads the weight before any same-edge write lands.
    assign w_sel_s = w_mem_r[idx];
    assign prod_s  = (2*DW)'(din) * (2*DW)'(w_sel_s);
    assign result  = DW'(sat_shift(64'(acc_r), SHIFT, DW));

    // Weight storage; deliberately kept across reset.
    always_ff @(posedge clk) begin
        if (we) begin
            w_mem_r[col] <= wdata;
        end
    end

    // Accumulator: cleared on reset or result handoff, otherwise MACs each accepted element.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (mac_en) begin
            acc_r <= acc_r + ACC_W'(prod_s);
        end
    end

endmodule

// File: rtl/matvec_stream_engine.sv
// N parallel row MACs consuming an M-element vector stream and handing the
// saturated N-element result downstream over valid/ready.
module matvec_stream_engine
    import matvec_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int M     = DEF_M,
    parameter int DW    = DEF_DW,
    parameter int SHIFT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_we,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] w_row,
    input  logic [((M > 1) ? $clog2(M) : 1)-1:0] w_col,
    input  logic [DW-1:0]       w_data,
    output logic                w_ready,
    input  logic                in_valid,
    input  logic [DW-1:0]       in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [N*DW-1:0]     out_vector,
    input  logic                out_ready,
    output logic                busy
);

    localparam int ACC_W = 2 * DW + $clog2(M);
    localparam int RW    = (N > 1) ? $clog2(N) : 1;
    localparam int IW    = (M > 1) ? $clog2(M) : 1;

    state_t        state_r;
    logic [IW-1:0] idx_r;
    logic          out_valid_r;
    logic          in_ready_r;
    logic          w_ready_r;
    logic          busy_r;
    logic          accept_s;
    logic          last_s;
    logic          out_hs_s;

    assign accept_s  = in_valid && in_ready_r;
    assign last_s    = (idx_r == IW'(M - 1));
    assign out_hs_s  = out_valid_r && out_ready;

    assign w_ready   = w_ready_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

    // Control FSM; handshake flags are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ACCUM;
            idx_r       <= {IW{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            w_ready_r   <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (accept_s) begin
                        busy_r    <= 1'b1;
                        w_ready_r <= 1'b0;
                        if (last_s) begin
                            state_r     <= OUT;
                            idx_r       <= {IW{1'b0}};
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r + IW'(1);
                        end
                    end
                end
                OUT: begin
                    if (out_hs_s) begin
                        state_r     <= ACCUM;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        w_ready_r   <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ACCUM;
                    idx_r       <= {IW{1'b0}};
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    w_ready_r   <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        logic row_we_s;
        assign row_we_s = w_we && w_ready_r && (w_row == RW'(i));

        matvec_row_mac #(
            .M     (M),
            .DW    (DW),
            .SHIFT (SHIFT),
            .ACC_W (ACC_W),
            .IW    (IW)
        ) u_row (
            .clk    (clk),
            .rst    (rst),
            .we     (row_we_s),
            .col    (w_col),
            .wdata  (w_data),
            .mac_en (accept_s),
            .idx    (idx_r),
            .din    (in_data),
            .clr    (out_hs_s),
            .result (out_vector[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_matvec_stream_engine.sv
// Directed bench for matvec_stream_engine at N=M=4, DW=8; a second instance
// with SHIFT=4 shares the stimulus for the rescale case.
module tb_matvec_stream_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_we;
    logic [1:0]  w_row;
    logic [1:0]  w_col;
    logic [7:0]  w_data;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        w_ready,  in_ready,  out_valid,  busy;
    logic        w_ready4, in_ready4, out_valid4, busy4;
    logic [31:0] out_vector, out_vector4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matvec_stream_engine #(.N(4), .M(4), .DW(8), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .w_we(w_we), .w_row(w_row), .w_col(w_col),
        .w_data(w_data), .w_ready(w_ready), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_vector(out_vector), .out_ready(out_ready), .busy(busy)
    );

    matvec_stream_engine #(.N(4), .M(4), .DW(8), .SHIFT(4)) dut4 (
        .clk(clk), .rst(rst), .w_we(w_we), .w_row(w_row), .w_col(w_col),
        .w_data(w_data), .w_ready(w_ready4), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready4), .out_valid(out_valid4),
        .out_vector(out_vector4), .out_ready(out_ready), .busy(busy4)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input logic [1:0] r, input logic [1:0] c, input logic [7:0] v);
        w_we = 1'b1; w_row = r; w_col = c; w_data = v;
        tick();
        w_we = 1'b0;
    endtask

    task automatic load_mat(input logic [7:0] diag, input logic [7:0] off);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                write_w(2'(r), 2'(c), (r == c) ? diag : off);
            end
        end
    endtask

    // Sends elements first..last of vec (element k in byte k); optional write of W[0][0]=5 with element 0.
    task automatic send_vec(input logic [31:0] vec, input int first, input int last, input bit wr0);
        for (int k = first; k <= last; k++) begin
            int t = 0;
            while (!in_ready && t < 20) begin
                tick();
                t++;
            end
            if (!in_ready) check_value("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_data  = vec[k*8 +: 8];
            if (wr0 && k == 0) begin
                w_we = 1'b1; w_row = 2'd0; w_col = 2'd0; w_data = 8'd5;
            end
            tick();
            in_valid = 1'b0;
            w_we     = 1'b0;
        end
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; w_we = 1'b0; w_row = 2'd0; w_col = 2'd0; w_data = 8'd0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check_value("rst_out_valid", 64'(out_valid), 64'd0);
        check_value("rst_out_vector", 64'(out_vector), 64'd0);
        check_value("rst_in_ready", 64'(in_ready), 64'd1);
        check_value("rst_w_ready", 64'(w_ready), 64'd1);
        check_value("rst_busy", 64'(busy), 64'd0);

        // Identity weights, latency of out_valid
        load_mat(8'd1, 8'd0);
        send_vec(32'hFC03FE01, 0, 2, 1'b0);
        check_value("id_valid_early", 64'(out_valid), 64'd0);
        check_value("id_busy", 64'(busy), 64'd1);
        check_value("id_w_ready_mid", 64'(w_ready), 64'd0);
        send_vec(32'hFC03FE01, 3, 3, 1'b0);
        check_value("id_valid", 64'(out_valid), 64'd1);
        check_value("id_vector", 64'(out_vector), 64'hFC03FE01);
        take_out();
        check_value("id_valid_drop", 64'(out_valid), 64'd0);
        check_value("id_busy_drop", 64'(busy), 64'd0);

        // Positive and negative saturation
        load_mat(8'd127, 8'd127);
        send_vec(32'h7F7F7F7F, 0, 3, 1'b0);
        check_value("sat_pos", 64'(out_vector), 64'h7F7F7F7F);
        check_value("sat_pos_shift4", 64'(out_vector4), 64'h7F7F7F7F);
        take_out();
        load_mat(8'h80, 8'h80);
        send_vec(32'h7F7F7F7F, 0, 3, 1'b0);
        check_value("sat_neg", 64'(out_vector), 64'h80808080);
        take_out();

        // Backpressure with a blocked input and an ignored weight write
        load_mat(8'd1, 8'd0);
        send_vec(32'h08070605, 0, 3, 1'b0);
        in_valid = 1'b1; in_data = 8'd9;
        for (int c = 0; c < 6; c++) begin
            w_we = (c == 2); w_row = 2'd1; w_col = 2'd1; w_data = 8'd99;
            tick();
            check_value("bp_vector", 64'(out_vector), 64'h08070605);
            check_value("bp_valid", 64'(out_valid), 64'd1);
            check_value("bp_in_ready", 64'(in_ready), 64'd0);
            check_value("bp_w_ready", 64'(w_ready), 64'd0);
        end
        w_we = 1'b0; in_valid = 1'b0;
        take_out();
        send_vec(32'h01010101, 0, 3, 1'b0);
        check_value("bp_restart", 64'(out_vector), 64'h01010101);
        take_out();

        // Write gating: mid-vector write ignored, idx==0 write applies to the next vector
        send_vec(32'h05040302, 0, 1, 1'b0);
        write_w(2'd0, 2'd0, 8'd5);
        send_vec(32'h05040302, 2, 3, 1'b0);
        check_value("gate_mid_ignored", 64'(out_vector), 64'h05040302);
        take_out();
        send_vec(32'h05040302, 0, 3, 1'b1);
        check_value("gate_old_weight", 64'(out_vector), 64'h05040302);
        take_out();
        send_vec(32'h05040302, 0, 3, 1'b0);
        check_value("gate_new_weight", 64'(out_vector), 64'h0504030A);
        take_out();

        // Reset mid-vector and during OUT keeps the weights
        send_vec(32'h0702FF03, 0, 1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("rmid_busy", 64'(busy), 64'd0);
        check_value("rmid_w_ready", 64'(w_ready), 64'd1);
        send_vec(32'h0702FF03, 0, 3, 1'b0);
        check_value("rmid_replay", 64'(out_vector), 64'h0702FF0F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("rout_valid", 64'(out_valid), 64'd0);
        check_value("rout_vector", 64'(out_vector), 64'd0);
        check_value("rout_in_ready", 64'(in_ready), 64'd1);

        // Rescale by SHIFT=4 on the second instance
        load_mat(8'd16, 8'd16);
        send_vec(32'h10101010, 0, 3, 1'b0);
        check_value("shift4_vector", 64'(out_vector4), 64'h40404040);
        check_value("shift0_vector", 64'(out_vector), 64'h7F7F7F7F);
        take_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matvec_stream_engine.md
Name: matvec_stream_engine

Overview:
- Parametrised successor to the fixed 64x64 int8 matrix-vector block.
- Holds an N x M signed weight matrix loaded through a write port.
- Consumes an M-element input vector streamed one element per cycle over a valid/ready handshake, with N row MACs running in parallel.
- Presents the N-element saturated result over a valid/ready output handshake. Sits between the activation stream source and the downstream layer buffer.

Parameters:
- N, 64, number of output rows (parallel MACs).
- M, 64, vector length / matrix columns.
- DW, 8, signed width of weights, input elements and output elements.
- SHIFT, 0, arithmetic right shift applied to each accumulator before saturation (fixed-point rescale).
- ACC_W, 2*DW+$clog2(M), signed accumulator width (derived, not overridden).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- w_we  in  1  weight write strobe.
- w_row  in  $clog2(N)  weight row address.
- w_col  in  $clog2(M)  weight column address.
- w_data  in  DW  signed weight value.
- w_ready  out  1  high when weight writes are accepted.
- in_valid  in  1  input element valid.
- in_data  in  DW  signed input element.
- in_ready  out  1  block accepts an input element.
- out_valid  out  1  result vector valid.
- out_vector  out  N x DW  signed saturated results, index i = row i.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high when at least one element of the current vector has been accepted, or a result is pending.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst).
  - On rst, state=ACCUM, col index=0, all accumulators=0.
  - Outputs: out_valid=0, out_vector=0, in_ready=1, w_ready=1, busy=0.
  - The weight array is NOT reset; it retains contents across rst.
- FSM has two states: ACCUM and OUT.
- ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: acc[i] <= acc[i] + in_data*W[i][idx] for all i in the same cycle; idx <= idx+1.
  - The product is a full-width signed 2*DW product, sign-extended to ACC_W. The accumulator cannot overflow by construction.
  - When the accepted element has idx==M-1: next state=OUT and idx <= 0.
- OUT:
  - in_ready=0; out_valid=1.
  - out_vector[i] = sat_DW(acc[i] >>> SHIFT), driven combinationally from registered accumulators. It is stable for the whole OUT state.
  - Saturation clamps to [-(2^(DW-1)), 2^(DW-1)-1].
  - On out_valid&&out_ready: acc cleared to 0, next state=ACCUM.
  - Held indefinitely while out_ready=0.
- Latency: out_valid rises the cycle after the M-th input handshake. Minimum vector period is M+1 cycles.
- Weight writes:
  - w_ready=1 only in ACCUM with idx==0 (no vector in flight).
  - w_we with w_ready=1 writes W[w_row][w_col] <= w_data at the clock edge.
  - w_we with w_ready=0 is ignored (no write, no error).
  - Writes take effect for the next vector.
- Simultaneous w_we and in_valid in ACCUM with idx==0: both are taken. The MAC for element 0 uses the OLD weight value. The write lands at the same edge.
- Reset mid-vector or during OUT: the partial vector is discarded, out_valid drops on the following cycle, and weights are kept.
- out_vector reads 0 (saturated zero acc) outside OUT after reset. Consumers qualify with out_valid only.

Decomposition:
- Shared package matvec_pkg:
  - Default N, M, DW.
  - Function sat_shift(acc, SHIFT) returning DW bits.
  - FSM state enum {ACCUM, OUT}.
- Sub-module matvec_row_mac: one row's weight column storage (M x DW), accumulator, and MAC/clear logic. Instantiated N times via generate.
- Top level holds the FSM, idx counter, handshakes and weight address decode.

Test Plan (N=4, M=4, DW=8, SHIFT=0 unless stated):
- Identity weights, stream [1,-2,3,-4] with in_valid held high -> out_valid 1 cycle after 4th handshake, out_vector=[1,-2,3,-4].
- Saturation:
  - All weights 127, vector [127,127,127,127] -> all outputs 127.
  - Weights -128, vector all 127 -> all outputs -128.
- Backpressure: out_ready=0 for 6 cycles -> out_vector stable, in_ready=0, w_ready=0. The new vector is accepted only after the out_ready handshake, and accumulators restart from 0.
- Weight-write gating:
  - w_we to W[0][0]=5 after the 2nd element is accepted -> ignored, result unchanged.
  - The same write at idx==0 concurrent with element 0 -> this vector uses the old weight, the next vector uses 5.
- Reset mid-vector: rst after 2 elements, then replay the full vector -> result equals the clean run using the retained weights.
- SHIFT=4, all weights 16, vector [16,16,16,16] -> acc 1024 >>> 4 = 64 per row.
